// File: rtl/cp0_irq_timer.sv
// Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC with
// 5-bit shift nesting, masked external interrupts, Count/Compare timer
// with prescaler, nesting depth tracking and a fixed exception vector.
module cp0_irq_timer #(
    parameter int          NUM_IRQ    = 6,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter int          MAX_NEST   = 4,
    parameter int          SHIFT      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         Rd,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [31:0]        pc,
    input  logic               exception,
    input  logic [4:0]         cause,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               intr_req,
    output logic               timer_int,
    output logic [31:0]        status,
    output logic [31:0]        exc_addr,
    output logic [2:0]         nest_depth,
    output logic               nest_ovf
);

    localparam logic [4:0]  RD_COUNT   = 5'd9;
    localparam logic [4:0]  RD_COMPARE = 5'd11;
    localparam logic [4:0]  RD_STATUS  = 5'd12;
    localparam logic [4:0]  RD_CAUSE   = 5'd13;
    localparam logic [4:0]  RD_EPC     = 5'd14;
    localparam logic [4:0]  RD_PRID    = 5'd15;
    localparam logic [31:0] PRID       = 32'h0000_5401;
    localparam logic [7:0]  PRESC_LAST = 8'(COUNT_DIV - 1);
    localparam logic [2:0]  NEST_MAX   = 3'(MAX_NEST);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_sw_int;
    logic [7:0]  r_presc;
    logic        r_timer_int;
    logic [2:0]  r_nest_depth;
    logic        r_nest_ovf;

    logic [5:0]  w_irq6;
    logic [5:0]  w_ip;
    logic [31:0] w_cause_rd;
    logic        w_wr_en;
    logic        w_wr_count;
    logic        w_wr_compare;

    // Map the external lines onto the six IP slots; unused slots read 0.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ip
            if (gi < NUM_IRQ) begin : g_used
                assign w_irq6[gi] = irq[gi];
            end else begin : g_unused
                assign w_irq6[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_ip       = w_irq6 | {r_timer_int, 5'b0};
    assign w_cause_rd = {16'b0, w_ip, r_sw_int, 1'b0, r_exc_code, 2'b0};

    // mtc0 only lands when neither an exception nor an eret owns the cycle.
    assign w_wr_en      = mtc0 && !exception && !eret;
    assign w_wr_count   = w_wr_en && (Rd == RD_COUNT);
    assign w_wr_compare = w_wr_en && (Rd == RD_COMPARE);

    assign intr_req   = r_status[0] & (|(w_ip & r_status[15:10]));
    assign exc_addr   = eret ? r_epc : EXC_VECTOR;
    assign timer_int  = r_timer_int;
    assign status     = r_status;
    assign nest_depth = r_nest_depth;
    assign nest_ovf   = r_nest_ovf;

    // Combinational register read port.
    always_comb begin
        rdata = 32'b0;
        if (mfc0) begin
            case (Rd)
                RD_COUNT:   rdata = r_count;
                RD_COMPARE: rdata = r_compare;
                RD_STATUS:  rdata = r_status;
                RD_CAUSE:   rdata = w_cause_rd;
                RD_EPC:     rdata = r_epc;
                RD_PRID:    rdata = PRID;
                default:    rdata = 32'b0;
            endcase
        end
    end

    // Free-running prescaled Count; a Count write restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'b0;
            r_presc <= 8'b0;
        end else if (w_wr_count) begin
            r_count <= wdata;
            r_presc <= 8'b0;
        end else if (r_presc == PRESC_LAST) begin
            r_count <= r_count + 32'd1;
            r_presc <= 8'b0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    // Compare register and sticky timer interrupt; a Compare write beats a match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_compare   <= 32'hFFFF_FFFF;
            r_timer_int <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare   <= wdata;
            r_timer_int <= 1'b0;
        end else if (r_count == r_compare) begin
            r_timer_int <= 1'b1;
        end
    end

    // Status/Cause/EPC and nesting: exception > eret > mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status     <= 32'b0;
            r_epc        <= 32'b0;
            r_exc_code   <= 5'b0;
            r_sw_int     <= 2'b0;
            r_nest_depth <= 3'b0;
            r_nest_ovf   <= 1'b0;
        end else if (exception) begin
            r_status   <= r_status << SHIFT;
            r_epc      <= pc;
            r_exc_code <= cause;
            r_sw_int   <= 2'b0;
            if (r_nest_depth == NEST_MAX) begin
                r_nest_ovf <= 1'b1;
            end else begin
                r_nest_depth <= r_nest_depth + 3'd1;
            end
        end else if (eret) begin
            r_status <= r_status >> SHIFT;
            if (r_nest_depth != 3'd0) begin
                r_nest_depth <= r_nest_depth - 3'd1;
            end
        end else if (mtc0) begin
            case (Rd)
                RD_STATUS: begin
                    r_status <= {1'b0, wdata[30:0]};
                    if (wdata[31]) begin
                        r_nest_ovf <= 1'b0;
                    end
                end
                RD_CAUSE: r_sw_int <= wdata[9:8];
                RD_EPC:   r_epc    <= wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed bench for cp0_irq_timer with hand-computed expectations.
module tb_cp0_irq_timer;

    localparam logic [31:0] VEC = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mfc0, mtc0, exception, eret;
    logic [4:0]  Rd, cause;
    logic [31:0] wdata, pc;
    logic [5:0]  irq;
    logic [31:0] rdata, status, exc_addr;
    logic        intr_req, timer_int, nest_ovf;
    logic [2:0]  nest_depth;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] v;

    cp0_irq_timer #(
        .NUM_IRQ(6), .COUNT_DIV(1), .EXC_VECTOR(VEC), .MAX_NEST(4), .SHIFT(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mfc0(mfc0), .mtc0(mtc0), .Rd(Rd),
        .wdata(wdata), .rdata(rdata), .pc(pc), .exception(exception),
        .cause(cause), .eret(eret), .irq(irq), .intr_req(intr_req),
        .timer_int(timer_int), .status(status), .exc_addr(exc_addr),
        .nest_depth(nest_depth), .nest_ovf(nest_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] idx, output logic [31:0] val);
        mfc0 = 1'b1;
        Rd   = idx;
        #1;
        val  = rdata;
        mfc0 = 1'b0;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        mtc0  = 1'b1;
        Rd    = idx;
        wdata = data;
        step();
        mtc0  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
        Rd = 0; cause = 0; wdata = 0; pc = 0; irq = 0;
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_status", status, 32'h0);
        chk("rst_exc_addr", exc_addr, VEC);
        chk("rst_intr_req", {31'b0, intr_req}, 32'h0);
        rst_n = 1'b1;
        step();

        rd(5'd11, v); chk("compare_reset", v, 32'hFFFF_FFFF);
        rd(5'd15, v); chk("prid", v, 32'h0000_5401);
        rd(5'd3, v);  chk("unmapped_rd", v, 32'h0);
        chk("rst_nest", {29'b0, nest_depth}, 32'h0);

        // Interrupt masking
        wr(5'd12, 32'h0000_0401);
        chk("status_wr", status, 32'h0000_0401);
        chk("intr_none", {31'b0, intr_req}, 32'h0);
        irq = 6'b000010; #1;
        chk("intr_masked", {31'b0, intr_req}, 32'h0);
        irq = 6'b000001; #1;
        chk("intr_live", {31'b0, intr_req}, 32'h1);
        rd(5'd13, v); chk("cause_ip_live", v, 32'h0000_0400);

        // Exception entry
        exception = 1'b1; cause = 5'd0; pc = 32'h0040_0100; #1;
        chk("exc_addr_vec", exc_addr, VEC);
        step();
        exception = 1'b0;
        chk("exc_status", status, 32'h0000_8020);
        rd(5'd14, v); chk("exc_epc", v, 32'h0040_0100);
        rd(5'd13, v); chk("exc_cause_code", {27'b0, v[6:2]}, 32'h0);
        chk("exc_nest", {29'b0, nest_depth}, 32'h1);
        chk("exc_intr_req", {31'b0, intr_req}, 32'h0);

        // eret
        eret = 1'b1; #1;
        chk("eret_exc_addr", exc_addr, 32'h0040_0100);
        step();
        eret = 1'b0;
        chk("eret_status", status, 32'h0000_0401);
        chk("eret_nest", {29'b0, nest_depth}, 32'h0);
        chk("eret_intr_req", {31'b0, intr_req}, 32'h1);
        irq = 6'b0;

        // Timer: Count=0, Compare=10
        wr(5'd9, 32'h0);
        wr(5'd11, 32'd10);
        rd(5'd9, v); chk("count_start", v, 32'd1);
        for (int i = 0; i < 9; i++) step();
        rd(5'd9, v); chk("count_at_cmp", v, 32'd10);
        chk("timer_before", {31'b0, timer_int}, 32'h0);
        step();
        chk("timer_rise", {31'b0, timer_int}, 32'h1);
        step(); step();
        chk("timer_sticky", {31'b0, timer_int}, 32'h1);
        rd(5'd13, v); chk("cause_timer_ip", v, 32'h0000_8000);
        wr(5'd12, 32'h0000_8001);
        chk("intr_timer", {31'b0, intr_req}, 32'h1);
        wr(5'd11, 32'd100);
        chk("timer_clear", {31'b0, timer_int}, 32'h0);
        chk("intr_timer_clr", {31'b0, intr_req}, 32'h0);

        // Nesting: five back-to-back exceptions
        exception = 1'b1; cause = 5'd4;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h0040_1000 + 32'(i * 4);
            step();
        end
        chk("nest_at_max", {29'b0, nest_depth}, 32'h4);
        chk("ovf_not_yet", {31'b0, nest_ovf}, 32'h0);
        pc = 32'h0040_2000;
        step();
        exception = 1'b0;
        chk("nest_sat", {29'b0, nest_depth}, 32'h4);
        chk("nest_ovf_set", {31'b0, nest_ovf}, 32'h1);
        rd(5'd14, v); chk("nest_epc", v, 32'h0040_2000);
        rd(5'd13, v); chk("nest_cause", v, 32'h0000_0010);
        wr(5'd12, 32'h8000_0001);
        chk("ovf_w1c", {31'b0, nest_ovf}, 32'h0);
        chk("status_b31", status, 32'h0000_0001);
        chk("nest_kept", {29'b0, nest_depth}, 32'h4);
        eret = 1'b1;
        for (int i = 0; i < 5; i++) step();
        eret = 1'b0;
        chk("nest_floor", {29'b0, nest_depth}, 32'h0);
        chk("eret_status0", status, 32'h0);

        // Cause write touches only the software bits
        wr(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v); chk("cause_sw", v, 32'h0000_0310);

        // Priority: exception beats mtc0 EPC, eret beats mtc0 Status
        exception = 1'b1; cause = 5'd2; pc = 32'h0040_0200;
        mtc0 = 1'b1; Rd = 5'd14; wdata = 32'hDEAD_BEEF;
        step();
        exception = 1'b0; mtc0 = 1'b0;
        rd(5'd14, v); chk("prio_exc_epc", v, 32'h0040_0200);
        rd(5'd13, v); chk("prio_exc_cause", v, 32'h0000_0008);
        wr(5'd12, 32'h0000_0020);
        eret = 1'b1; mtc0 = 1'b1; Rd = 5'd12; wdata = 32'h0000_FFFF;
        step();
        eret = 1'b0; mtc0 = 1'b0;
        chk("prio_eret_status", status, 32'h0000_0001);

        // Count wrap
        wr(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, v); chk("count_max", v, 32'hFFFF_FFFF);
        step();
        rd(5'd9, v); chk("count_wrap", v, 32'h0);

        // Asynchronous reset mid-count
        wr(5'd9, 32'h0000_1234);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        rd(5'd9, v); chk("async_count", v, 32'h0);
        chk("async_status", status, 32'h0);
        rd(5'd11, v); chk("async_compare", v, 32'hFFFF_FFFF);
        #1 rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
